// File: rtl/id_ex_reg_pkg.sv
// Shared types for the ID/EX pipeline register: widths, NOP encoding,
// FSM states and the decoded-instruction bundle.
package id_ex_reg_pkg;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int ALEN  = 64;
  localparam int RALEN = 5;

  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ILEN-1:0]  inst;
    logic [ALEN-1:0]  inst_addr;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic             reg_we;
    logic [RALEN-1:0] reg_waddr;
  } id_ex_t;

  // Bubbles reach the ALU as a canonical NOP with no side effects.
  function automatic id_ex_t id_ex_mask(
    input id_ex_t e,
    input logic   v
  );
    id_ex_t r;
    r      = '0;
    r.inst = INST_NOP;
    if (v) r = e;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_reg_entry.sv
// One payload slot of the ID/EX register: load enable plus
// synchronous clear.
module id_ex_reg_entry
  import id_ex_reg_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   load,
  input  id_ex_t d,
  output id_ex_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush and stall counter.
// Define ID_EX_SKID_EN for a skid slot and registered in_ready.
module id_ex_reg
  import id_ex_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ILEN-1:0]  in_inst,
  input  logic [ALEN-1:0]  in_inst_addr,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic             in_reg_we,
  input  logic [RALEN-1:0] in_reg_waddr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ILEN-1:0]  out_inst,
  output logic [ALEN-1:0]  out_inst_addr,
  output logic [XLEN-1:0]  out_op1,
  output logic [XLEN-1:0]  out_op2,
  output logic             out_reg_we,
  output logic [RALEN-1:0] out_reg_waddr,
  output logic [31:0]      stall_cnt
);

  state_e      state;
  state_e      state_nx;
  logic        valid;
  logic        in_xfer;
  logic        out_xfer;
  logic        main_ld;
  id_ex_t      in_e;
  id_ex_t      main_d;
  id_ex_t      main_q;
  id_ex_t      out_e;
  logic [31:0] stall_cnt_q;

  assign in_e.inst      = in_inst;
  assign in_e.inst_addr = in_inst_addr;
  assign in_e.op1       = in_op1;
  assign in_e.op2       = in_op2;
  assign in_e.reg_we    = in_reg_we;
  assign in_e.reg_waddr = in_reg_waddr;

  assign valid    = (state != ST_EMPTY);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = valid & out_ready;

`ifdef ID_EX_SKID_EN

  logic   skid_ld;
  logic   in_ready_q;
  id_ex_t skid_q;

  assign in_ready = in_ready_q;

  always_comb begin
    state_nx = state;
    main_ld  = 1'b0;
    skid_ld  = 1'b0;
    main_d   = in_e;
    if (flush) begin
      state_nx = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_nx = ST_FULL;
            main_ld  = 1'b1;
          end
        end
        ST_FULL: begin
          unique case (1'b1)
            in_xfer && out_xfer: begin
              main_ld = 1'b1;
            end
            in_xfer && !out_xfer: begin
              state_nx = ST_SKID;
              skid_ld  = 1'b1;
            end
            !in_xfer && out_xfer: begin
              state_nx = ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_SKID: begin
          // in_ready is low here, so only a drain can happen.
          if (out_xfer) begin
            state_nx = ST_FULL;
            main_ld  = 1'b1;
            main_d   = skid_q;
          end
        end
        default: state_nx = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nx;
      in_ready_q <= (state_nx != ST_SKID);
    end
  end

  id_ex_reg_entry u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .load  (skid_ld),
    .d     (in_e),
    .q     (skid_q)
  );

`else

  assign in_ready = !valid | out_ready;
  assign main_d   = in_e;

  always_comb begin
    state_nx = state;
    main_ld  = 1'b0;
    if (flush) begin
      state_nx = ST_EMPTY;
    end else if (in_xfer) begin
      state_nx = ST_FULL;
      main_ld  = 1'b1;
    end else if (out_xfer) begin
      state_nx = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

`endif

  id_ex_reg_entry u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .load  (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (valid && !out_ready) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign out_e = id_ex_mask(main_q, valid);

  assign out_valid     = valid;
  assign out_inst      = out_e.inst;
  assign out_inst_addr = out_e.inst_addr;
  assign out_op1       = out_e.op1;
  assign out_op2       = out_e.op2;
  assign out_reg_we    = out_e.reg_we;
  assign out_reg_waddr = out_e.reg_waddr;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, streaming, stall,
// flush, write masking and stall counter wrap.
module tb_id_ex_reg;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_inst_addr;
  logic [63:0] in_op1;
  logic [63:0] in_op2;
  logic        in_reg_we;
  logic [4:0]  in_reg_waddr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_inst_addr;
  logic [63:0] out_op1;
  logic [63:0] out_op2;
  logic        out_reg_we;
  logic [4:0]  out_reg_waddr;
  logic [31:0] stall_cnt;

  int nchecks = 0;
  int nerr    = 0;

  id_ex_reg dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inst       (in_inst),
    .in_inst_addr  (in_inst_addr),
    .in_op1        (in_op1),
    .in_op2        (in_op2),
    .in_reg_we     (in_reg_we),
    .in_reg_waddr  (in_reg_waddr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_inst_addr (out_inst_addr),
    .out_op1       (out_op1),
    .out_op2       (out_op2),
    .out_reg_we    (out_reg_we),
    .out_reg_waddr (out_reg_waddr),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addi(input int rd, input int imm);
    logic [11:0] i12;
    logic [4:0]  r5;
    i12 = 12'(imm);
    r5  = 5'(rd);
    return {i12, 5'd0, 3'b000, r5, 7'h13};
  endfunction

  task automatic drive(
    input logic        v,
    input logic [31:0] inst,
    input logic [63:0] pc,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        we,
    input logic [4:0]  wa
  );
    in_valid     = v;
    in_inst      = inst;
    in_inst_addr = pc;
    in_op1       = a;
    in_op2       = b;
    in_reg_we    = we;
    in_reg_waddr = wa;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, addi(9, 9), 64'h100, 64'd1, 64'd2, 1'b1, 5'd9);

    // Reset with a handshake in flight
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'h13);
    chk("rst_out_op1", out_op1, 64'd0);
    chk("rst_out_reg_we", 64'(out_reg_we), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // Streaming: 8 back-to-back ADDIs
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, addi(i + 1, i), 64'h8000_0000 + 64'(4 * i),
            64'(i), 64'(3 * i), 1'b1, 5'(i + 1));
      #1;
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_inst", 64'(out_inst), 64'(addi(i + 1, i)));
      chk("stream_pc", out_inst_addr, 64'h8000_0000 + 64'(4 * i));
      chk("stream_op2", out_op2, 64'(3 * i));
      chk("stream_waddr", 64'(out_reg_waddr), 64'(i + 1));
    end
    drive(1'b0, 32'd0, 64'd0, 64'd0, 64'd0, 1'b0, 5'd0);
    tick();
    chk("stream_drain", 64'(out_valid), 64'd0);
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // Stall: A held, B waits (or skids)
    drive(1'b1, addi(10, 100), 64'hA0, 64'hAA, 64'hA1, 1'b1, 5'd10);
    tick();
    chk("stall_a_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    drive(1'b1, addi(11, 200), 64'hB0, 64'hBB, 64'hB1, 1'b1, 5'd11);
    #1;
`ifdef ID_EX_SKID_EN
    chk("stall_in_ready_pre", 64'(in_ready), 64'd1);
    tick();
    chk("stall_skid_full", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    tick();
    tick();
`else
    chk("stall_in_ready_pre", 64'(in_ready), 64'd0);
    tick();
    tick();
    tick();
    chk("stall_in_ready", 64'(in_ready), 64'd0);
`endif
    chk("stall_a_held", 64'(out_inst), 64'(addi(10, 100)));
    chk("stall_a_op1", out_op1, 64'hAA);
    chk("stall_cnt3", 64'(stall_cnt), 64'd3);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("stall_b_out", 64'(out_inst), 64'(addi(11, 200)));
    chk("stall_b_pc", out_inst_addr, 64'hB0);
    tick();
    chk("stall_drained", 64'(out_valid), 64'd0);
    chk("stall_cnt_keep", 64'(stall_cnt), 64'd3);

    // Flush while holding entries, with C offered
    out_ready = 1'b0;
    drive(1'b1, addi(12, 1), 64'hA4, 64'h1, 64'h2, 1'b1, 5'd12);
    tick();
`ifdef ID_EX_SKID_EN
    drive(1'b1, addi(13, 2), 64'hB4, 64'h3, 64'h4, 1'b1, 5'd13);
    tick();
`endif
    drive(1'b1, addi(14, 3), 64'hC4, 64'h5, 64'h6, 1'b1, 5'd14);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_reg_we", 64'(out_reg_we), 64'd0);
    chk("flush_inst", 64'(out_inst), 64'h13);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
`ifdef ID_EX_SKID_EN
    chk("flush_stall_cnt", 64'(stall_cnt), 64'd5);
`else
    chk("flush_stall_cnt", 64'(stall_cnt), 64'd4);
`endif
    out_ready = 1'b1;
    tick();
    chk("flush_c_lost", 64'(out_valid), 64'd0);

    // Write-back masking on a bubble
    drive(1'b1, addi(5, 7), 64'hD0, 64'h7, 64'h8, 1'b1, 5'd5);
    tick();
    chk("wm_we_on", 64'(out_reg_we), 64'd1);
    chk("wm_waddr", 64'(out_reg_waddr), 64'd5);
    in_valid = 1'b0;
    tick();
    chk("wm_we_off", 64'(out_reg_we), 64'd0);
    chk("wm_waddr_off", 64'(out_reg_waddr), 64'd0);
    chk("wm_op1_off", out_op1, 64'd0);

    // Stall counter wrap
    out_ready = 1'b0;
    drive(1'b1, addi(6, 1), 64'hE0, 64'h1, 64'h1, 1'b0, 5'd6);
    tick();
    in_valid = 1'b0;
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    #1;
    chk("wrap_pre", 64'(stall_cnt), 64'hFFFF_FFFF);
    tick();
    chk("wrap_post", 64'(stall_cnt), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("wrap_done", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

Pipeline register between the instruction decoder and the ALU in the NPC core. It captures the decoded instruction, PC, two operands and the write-back control on a valid/ready handshake and presents them to the ALU one cycle later. It supports stall (backpressure), synchronous flush (redirect bubble), and an optional two-entry skid buffer so the upstream ready signal is registered.

## Interface
- XLEN, 64, operand and register width.
- ILEN, 32, instruction width.
- ALEN, 64, instruction address width.
- RALEN, 5, register address width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset: synchronous, active-low.
- flush  in  1  drop all held and incoming entries this cycle.
- in_valid  in  1  decoder presents a valid entry.
- in_ready  out  1  block accepts the entry this cycle.
- in_inst  in  ILEN  instruction word.
- in_inst_addr  in  ALEN  instruction PC.
- in_op1, in_op2  in  XLEN  operands.
- in_reg_we  in  1  write-back enable.
- in_reg_waddr  in  RALEN  write-back register.
- out_valid  out  1  entry presented to the ALU.
- out_ready  in  1  ALU/downstream consumes the entry.
- out_inst  out  ILEN  instruction, or NOP 0x00000013 when out_valid=0.
- out_inst_addr, out_op1, out_op2  out  ALEN/XLEN  payload, 0 when out_valid=0.
- out_reg_we  out  1  stored we AND out_valid.
- out_reg_waddr  out  RALEN  payload, 0 when out_valid=0.
- stall_cnt  out  32  cycles with out_valid=1 and out_ready=0.

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Without skid: states EMPTY, FULL. in_ready = !out_valid | out_ready (combinational through). EMPTY + in xfer -> FULL; FULL + out xfer, no in xfer -> EMPTY; FULL + both -> FULL with new payload.
- With skid: states EMPTY, FULL, SKID (main + skid entry). in_ready = (state != SKID), registered. FULL + in xfer, no out xfer -> SKID, incoming goes into skid entry. SKID + out xfer -> FULL, skid entry moves to main. SKID never accepts input.
- Flush: next state EMPTY, all valid bits cleared, any same-cycle in xfer discarded; flush wins over every other event. stall_cnt is not cleared by flush.
- Payload registers load only on accept; invalid outputs are masked to NOP/zeros combinationally from the valid bit.
- stall_cnt increments modulo 2^32.
- rst_n low at a clock edge: state EMPTY, stall_cnt 0, payload registers 0, regardless of handshakes in flight.

## Timing
- Reset values: out_valid 0, out_inst 0x00000013, all other payload outputs 0, out_reg_we 0, stall_cnt 0, in_ready 1 (both configurations).
- Latency: entry accepted at edge N is on outputs after edge N; out_valid is high during cycle N+1.
- Throughput: one entry per cycle when out_ready is held high.
- Without skid, in_ready depends combinationally on out_ready; with skid, no combinational path from out_* to in_*.
- Flush asserted in cycle N: out_valid=0 from cycle N+1.

## Configuration
- ID_EX_SKID_EN defined: three-state FSM with skid entry, registered in_ready; accepts one more entry after downstream stalls.
- ID_EX_SKID_EN undefined: two-state FSM, no skid storage, in_ready = !out_valid | out_ready.
- Port list identical in both builds.

## Structure
- Shared header/package: XLEN, ILEN, ALEN, RALEN, NOP encoding 0x00000013, FSM state encodings (EMPTY=0, FULL=1, SKID=2).
- One sub-module natural: id_ex_entry, a payload register bundle with load enable and synchronous clear, instantiated once (main) or twice (main + skid).
- FSM, masking and stall counter live in the top.

## Test plan
- Reset: hold rst_n=0 two cycles with in_valid=1 -> out_valid=0, out_inst=0x00000013, stall_cnt=0, in_ready=1.
- Streaming: 8 back-to-back ADDI entries, out_ready=1 -> each appears one cycle later in order, no bubbles, stall_cnt stays 0.
- Stall: entry A accepted, out_ready=0 for 3 cycles -> A held stable, stall_cnt=3; skid build accepts B then in_ready=0; non-skid build in_ready=0 immediately; release -> A then B.
- Flush: SKID state (A,B held) plus in_valid with C and flush=1 -> next cycle out_valid=0, out_reg_we=0, C lost, in_ready=1.
- Write masking: entry with in_reg_we=1, in_reg_waddr=5, then bubble -> out_reg_we=1 for one cycle, then 0 with out_reg_waddr=0.
- Counter wrap: force stall_cnt to 0xFFFFFFFF, one stall cycle -> 0x00000000.
